// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch/decode packet types, NOP encoding and fetch FSM states
package inst_fetch_pkg;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [29:0] pc;
    logic        pc_valid;
  } dec2if_pkt_t;
  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] inst32;
    logic        inst_valid;
  } if2dec_pkt_t;
  typedef enum logic [1:0] {IDLE, REQ, HOLD} fetch_state_t;
endpackage

// File: rtl/inst_fetch_hold_buf.sv
// fetch_hold_buf: single-entry skid register parking one fetched {pc, inst} while decode stalls
module fetch_hold_buf #(
  parameter int W = 62
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  // load wins over drain; data only moves on load
  always_comb begin
    valid_d = load_i ? 1'b1 : (drain_i ? 1'b0 : valid_q);
    data_d  = load_i ? data_i : data_q;
  end
  // entry register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: issues imem word requests for decode's next pc and returns fetched instructions
module inst_fetch import inst_fetch_pkg::*; #(
  parameter int          MAX_WAIT = 16,
  parameter logic [31:0] NOP_INST = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_stall_i,
  input  logic [30:0] dec2if_i,
  output logic [62:0] if2dec_o,
  output logic        imem_req_o,
  output logic [29:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        fetch_stall_o,
  output logic        imem_err_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  dec2if_pkt_t  dec;
  fetch_state_t state_q, state_d;
  if2dec_pkt_t  pkt_q, pkt_d;
  logic [29:0]  addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;
  logic         hb_load, hb_drain, hb_valid;
  logic [61:0]  hb_data;
  assign dec = dec2if_pkt_t'(dec2if_i);
  fetch_hold_buf #(.W(62)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (hb_load),
    .drain_i(hb_drain),
    .data_i ({addr_q, imem_rdata_i}),
    .valid_o(hb_valid),
    .data_o (hb_data)
  );
  // next state, request address, output packet, wait counter and sticky timeout
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pkt_d    = dec_stall_i ? pkt_q : '{pc: pkt_q.pc, inst32: NOP_INST, inst_valid: 1'b0};
    cnt_d    = '0;
    err_d    = err_q;
    hb_load  = 1'b0;
    hb_drain = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d  = dec.pc_valid ? dec.pc : addr_q;
        state_d = dec.pc_valid ? REQ : IDLE;
      end
      REQ: begin
        err_d = err_q | (cnt_q >= CW'(MAX_WAIT - 1));
        cnt_d = imem_ack_i ? '0 : (cnt_q >= CW'(MAX_WAIT) ? cnt_q : cnt_q + 1'b1);
        if (imem_ack_i && dec_stall_i) begin
          hb_load = 1'b1;
          state_d = HOLD;
        end else if (imem_ack_i) begin
          pkt_d   = '{pc: addr_q, inst32: imem_rdata_i, inst_valid: 1'b1};
          addr_d  = dec.pc_valid ? dec.pc : addr_q;
          state_d = dec.pc_valid ? REQ : IDLE;
        end
      end
      HOLD: begin
        if (!dec_stall_i) begin
          pkt_d    = if2dec_pkt_t'({hb_data, hb_valid});
          hb_drain = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pkt_q   <= '{pc: '0, inst32: NOP_INST, inst_valid: 1'b0};
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign if2dec_o      = pkt_q;
  assign imem_req_o    = state_q == REQ;
  assign imem_addr_o   = addr_q;
  assign fetch_stall_o = (state_q == REQ && !imem_ack_i) || state_q == HOLD;
  assign imem_err_o    = err_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus checked against a queue-based fetch model plus literal expectations
module tb_inst_fetch;
  localparam int          MAX_WAIT = 16;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, pcv = 1'b0, ack = 1'b0;
  logic [29:0] pc = '0;
  logic [31:0] rdata = '0;
  logic [62:0] if2dec;
  logic        req, fstall, err;
  logic [29:0] addr;
  int          n_cmp = 0, n_bad = 0;
  inst_fetch #(.MAX_WAIT(MAX_WAIT), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_stall_i  (stall),
    .dec2if_i     ({pc, pcv}),
    .if2dec_o     (if2dec),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_ack_i   (ack),
    .imem_rdata_i (rdata),
    .fetch_stall_o(fstall),
    .imem_err_o   (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [62:0] got, input logic [62:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask
  // model: at most one outstanding pc, at most one parked instruction
  logic [29:0] pend[$];
  logic [61:0] held[$];
  logic [62:0] out_m;
  logic [29:0] addr_m;
  int          wait_n;
  bit          err_m;
  always @(negedge clk) begin
    logic [62:0] nxt;
    logic [29:0] p;
    bit          done;
    if (rst) begin
      pend.delete();
      held.delete();
      out_m  = {30'h0, NOP, 1'b0};
      addr_m = '0;
      wait_n = 0;
      err_m  = 0;
    end
    chk("if2dec", if2dec, out_m);
    chk("req", 63'(req), 63'(pend.size() != 0));
    chk("addr", 63'(addr), 63'(addr_m));
    chk("fetch_stall", 63'(fstall), 63'((pend.size() != 0 && !ack) || held.size() != 0));
    chk("err", 63'(err), 63'(err_m));
    if (!rst) begin
      nxt  = out_m;
      done = 0;
      if (pend.size() != 0) begin
        if (wait_n < MAX_WAIT) wait_n++;
        if (wait_n >= MAX_WAIT) err_m = 1;
        if (ack) begin
          wait_n = 0;
          p = pend.pop_front();
          if (stall) held.push_back({p, rdata});
          else begin
            nxt  = {p, rdata, 1'b1};
            done = 1;
            if (pcv) begin
              pend.push_back(pc);
              addr_m = pc;
            end
          end
        end
      end else if (held.size() != 0) begin
        if (!stall) begin
          nxt  = {held.pop_front(), 1'b1};
          done = 1;
        end
      end else if (pcv) begin
        pend.push_back(pc);
        addr_m = pc;
      end
      if (!stall && !done) nxt = {out_m[62:33], NOP, 1'b0};
      out_m = nxt;
    end
  end
  task automatic drive(input logic s, input logic v, input logic [29:0] p, input logic a, input logic [31:0] d);
    stall = s;
    pcv   = v;
    pc    = p;
    ack   = a;
    rdata = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("lit_reset_pkt", if2dec, {30'h0, 32'h0000_0013, 1'b0});
    chk("lit_reset_req", 63'(req), 63'(0));
    chk("lit_reset_addr", 63'(addr), 63'(0));
    drive(0, 1, 30'h0, 0, 0);
    chk("lit_first_addr", 63'(addr), 63'(0));
    chk("lit_first_req", 63'(req), 63'(1));
    drive(0, 0, 0, 1, 32'h0010_0093);
    chk("lit_first_pkt", if2dec, {30'h0, 32'h0010_0093, 1'b1});
    drive(0, 0, 0, 0, 0);
    chk("lit_bubble", if2dec, {30'h0, 32'h0000_0013, 1'b0});
    drive(0, 1, 30'h0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, k < 3, 30'(k + 1), 1, 32'h00A0_0000 + 32'(k));
      chk("lit_stream", if2dec, {30'(k), 32'h00A0_0000 + 32'(k), 1'b1});
    end
    drive(0, 1, 30'h10, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0);
      chk("lit_slow_addr", 63'(addr), 63'(30'h10));
    end
    drive(0, 0, 0, 1, 32'h0041_8193);
    chk("lit_slow_pkt", if2dec, {30'h10, 32'h0041_8193, 1'b1});
    drive(0, 1, 30'h20, 0, 0);
    drive(1, 0, 0, 1, 32'h0020_8133);
    chk("lit_stall_hold", if2dec, {30'h10, 32'h0000_0013, 1'b0});
    chk("lit_stall_noreq", 63'(req), 63'(0));
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("lit_stall_still", if2dec, {30'h10, 32'h0000_0013, 1'b0});
    drive(0, 0, 0, 0, 0);
    chk("lit_stall_release", if2dec, {30'h20, 32'h0020_8133, 1'b1});
    drive(0, 1, 30'h30, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      drive(0, 0, 0, 0, 0);
      if (k == 15) chk("lit_err_pre", 63'(err), 63'(0));
    end
    chk("lit_err_set", 63'(err), 63'(1));
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h0030_0213);
    chk("lit_err_pkt", if2dec, {30'h30, 32'h0030_0213, 1'b1});
    chk("lit_err_sticky", 63'(err), 63'(1));
    drive(0, 0, 0, 0, 0);
    chk("lit_err_sticky2", 63'(err), 63'(1));
    drive(0, 1, 30'h40, 0, 0);
    chk("lit_rreq_req", 63'(req), 63'(1));
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h0050_0293);
    chk("lit_rreq_valid", 63'(if2dec[0]), 63'(0));
    chk("lit_rreq_noreq", 63'(req), 63'(0));
    chk("lit_rreq_err", 63'(err), 63'(0));
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage. It sits directly upstream of the decode stage.
- Takes the next-PC packet (dec2ifPkt) computed by decode and issues a word request to instruction memory over a req/ack handshake with variable latency.
- Returns the fetched instruction to decode as an if2decPkt.
- Buffers one response while decode is stalled, and raises fetch_stall_o while a fetch is outstanding.

Parameters:
- MAX_WAIT, 16: cycles of req-without-ack before imem_err_o is set.
- NOP_INST, 32'h0000_0013: filler instruction (ADDI x0,x0,0) placed on if2dec_o when no valid instruction is present.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- dec_stall_i  in  1  decode stall; the output packet must be held
- dec2if_i  in  31  dec2ifPkt {pc[31:2], pcValid}
- if2dec_o  out  63  if2decPkt {pc[31:2], inst32[31:0], instValid}
- imem_req_o  out  1  memory request
- imem_addr_o  out  30  word address
- imem_ack_i  in  1  response valid; imem_rdata_i is valid in the same cycle
- imem_rdata_i  in  32  instruction word
- fetch_stall_o  out  1  fetch not ready; decode must hold nextPc
- imem_err_o  out  1  sticky timeout flag

Behaviour:
- Reset, asynchronous and active-high, forces:
  - state = IDLE, imem_req_o = 0, imem_addr_o = 0
  - if2dec_o = {30'h0, NOP_INST, 1'b0}
  - hold buffer invalid, wait counter = 0, imem_err_o = 0
- Reset mid-request abandons the transaction. An ack arriving in IDLE is ignored.
- State machine IDLE / REQ / HOLD:
  - IDLE: when dec2if_i.pcValid=1, latch pc into imem_addr_o, assert imem_req_o, go to REQ.
  - REQ: imem_req_o=1. imem_addr_o must stay stable until ack. The wait counter increments each cycle.
  - REQ, on imem_ack_i with dec_stall_i=0:
    - if2dec_o <= {addr, rdata, 1}.
    - If pcValid=1 in the same cycle, relatch the new pc and stay in REQ (back-to-back; one instruction per cycle when memory acks every cycle). Otherwise go to IDLE.
  - REQ, on imem_ack_i with dec_stall_i=1: capture {addr, rdata} into the hold buffer, drop imem_req_o, go to HOLD.
  - HOLD: no request issued. When dec_stall_i falls, if2dec_o <= hold buffer with instValid=1, then go to IDLE.
- if2dec_o update rule:
  - It changes only in a cycle with dec_stall_i=0.
  - In a non-stalled cycle with no new instruction delivered, instValid <= 0 and inst32 <= NOP_INST.
  - While dec_stall_i=1 it holds its value exactly.
- fetch_stall_o = (REQ && !imem_ack_i) || HOLD. It is combinational and 0 in IDLE.
- Timeout:
  - The counter saturates at MAX_WAIT and clears on ack.
  - On reaching MAX_WAIT, set imem_err_o, which is sticky until reset.
  - The request continues; the stage does not self-abort.
- An ack in the cycle the counter reaches MAX_WAIT completes normally, and the error is still set.
- PC width: pc carries bits [31:2] only; bits [1:0] are implicitly 0.
- Fetch latency: one cycle from ack to if2dec_o.

Decomposition:
- Shared package (alongside the RISC-V ISA header):
  - if2decPkt and dec2ifPkt typedefs.
  - A NOP encoding constant, RV_NOP = 32'h0000_0013.
  - A fetch_state_t enum {IDLE, REQ, HOLD}.
- One natural sub-module: fetch_hold_buf, a single-entry skid register with valid, load and drain.

Test Plan:
- Reset:
  - Stimulus: rst pulse, then pcValid=1, pc=30'h0; memory acks the following cycle with rdata=32'h0010_0093.
  - Response: imem_addr_o=0, then if2dec_o={0, 32'h0010_0093, 1}.
- Zero-wait stream:
  - Stimulus: ack every cycle while decode supplies pc 0,1,2,3.
  - Response: if2dec_o delivers 4 consecutive valid instructions, and fetch_stall_o stays 0.
- Slow memory:
  - Stimulus: ack 3 cycles after req.
  - Response: fetch_stall_o=1 for 3 cycles, imem_addr_o stable throughout, one valid packet after the ack.
- Decode stall during ack:
  - Stimulus: dec_stall_i=1 in the ack cycle and for 2 more cycles.
  - Response: state HOLD, if2dec_o unchanged; the held instruction appears the cycle after the stall falls.
- Timeout:
  - Stimulus: no ack for 16 cycles.
  - Response: imem_err_o=1 and stays 1 after a later ack; the instruction is still delivered.
- Reset in REQ:
  - Stimulus: assert rst while req=1, then ack 1 cycle after reset releases.
  - Response: ack ignored, if2dec_o.instValid=0, imem_req_o=0.
